priority_arb_mux: RTL and testbench
===================================

# priority_arb_mux

- Packet-level N:1 multiplexer that sits directly downstream of the fixed-priority request arbitration stage.
- Collects N valid/ready requester channels and picks the lowest-index requester with a fixed-priority grant.
- Holds that grant until the requester's `last` beat completes, then forwards the beats through a one-entry registered output stage to a single valid/ready consumer.
- Guarantees packets from different requesters never interleave.

## Interface
Parameters:
- N, 4, number of requester ports (N ≥ 2)
- DW, 32, payload width per beat
- PW, $clog2(N), port-index width (derived, not overridden)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  N  per-port beat valid
- in_data  in  N*DW  per-port payload, port i at [i*DW +: DW]
- in_last  in  N  per-port last-beat-of-packet flag
- in_ready  out  N  per-port beat accept
- out_valid  out  1  output beat valid
- out_data  out  DW  output payload
- out_last  out  1  output last-beat flag
- out_port  out  PW  index of the source port of the current output beat
- out_ready  in  1  consumer accept
- pkt_cnt  out  N*16  per-port completed-packet counters; present only with PRIORITY_ARB_MUX_STATS_EN

## Operation
- FSM states: IDLE, LOCK.
- IDLE:
  - in_ready = 0.
  - If any in_valid, register sel = lowest index i with in_valid[i] = 1 and go to LOCK.
  - Otherwise stay in IDLE.
- LOCK:
  - in_ready[sel] = (!out_valid || out_ready); all other in_ready bits = 0.
  - Beat accepted when in_valid[sel] && in_ready[sel]: load out_data/out_last/out_port = in_data[sel]/in_last[sel]/sel, and set out_valid = 1.
  - Accepted beat with in_last[sel] = 1: go to IDLE in the next cycle.
- Output register:
  - Cleared when out_valid && out_ready and no new beat is loaded in the same cycle.
  - Simultaneous drain and load: new beat replaces the old one, and out_valid stays 1.
- Grant is held for the whole packet. A higher-priority request arriving mid-packet waits for the current packet to end.
- in_valid[sel] dropping mid-packet: stay in LOCK and wait. Packets are never abandoned.
- Single-beat packets (in_last on the first beat) are legal.
- Re-arbitration happens only in IDLE. Fixed priority means port 0 can starve the others; this is intended.
- in_data/in_last on unselected ports are ignored.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, out_port 0, in_ready 0, state IDLE, sel 0, pkt_cnt 0.
- Reset asserted mid-packet:
  - Everything returns to reset values immediately.
  - A held output beat is discarded.
  - After reset release, arbitration restarts from IDLE.
- Latency, in_valid rising in IDLE at cycle 0:
  - Cycle 1: LOCK, in_ready[sel] = 1, first beat accepted.
  - Cycle 2: out_valid = 1.
- Steady-state throughput: one beat per cycle while out_ready = 1.
- Packet-to-packet gap: one IDLE cycle after every packet. Back-to-back packets therefore cost one bubble on in_ready.
- out_* is stable while out_valid && !out_ready.

## Configuration
- PRIORITY_ARB_MUX_STATS_EN defined:
  - Adds port pkt_cnt.
  - Counter i increments by one in the cycle a beat with in_last = 1 is accepted from port i.
  - Counters saturate at 16'hFFFF and are cleared only by rst_n.
- Undefined: the pkt_cnt port and its counters are absent. All other behaviour is identical.

## Structure
- Package priority_arb_mux_pkg holds:
  - state enum {IDLE, LOCK}
  - constant PKT_CNT_W = 16
  - constant PKT_CNT_MAX = 16'hFFFF
- One sub-module, prio_sel_enc: combinational, N-bit request vector to one-hot lowest-index grant plus PW-bit index plus any flag.
- Everything else (FSM, output register, counters) lives in priority_arb_mux.

## Test plan
- Single request: port 2 sends a 3-beat packet (A,B,C) with out_ready = 1 -> out_valid at cycles 2-4, out_port = 2, out_last only with C, then one IDLE cycle.
- Priority: ports 1 and 3 both valid in IDLE -> port 1's full packet is output first, then port 3's after one IDLE cycle.
- Lock: port 0 raises in_valid while port 2 is mid-packet -> port 2's packet completes uninterrupted, then port 0 is granted.
- Backpressure: out_ready = 0 for 4 cycles mid-packet -> out_data held stable, in_ready[sel] = 0 while out_valid && !out_ready, no beat lost or duplicated.
- Reset mid-packet: rst_n low during beat 2 of 4 -> outputs go to zero immediately; after release, a new request is granted with 2-cycle latency.
- Stats (with PRIORITY_ARB_MUX_STATS_EN): 3 packets from port 1 -> pkt_cnt slice 1 = 3, others 0. Forced counter at FFFF plus one more packet -> stays FFFF.

Source files
------------

// File: rtl/priority_arb_mux_pkg.sv
// Shared types and constants for the priority_arb_mux packet multiplexer.
package priority_arb_mux_pkg;

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   localparam int          PKT_CNT_W   = 16;
   localparam logic [15:0] PKT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/prio_sel_enc.sv
// Fixed-priority encoder: the lowest-index set request wins.
// Produces a one-hot grant, the winning index, and an any-request flag.
module prio_sel_enc #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   // Scanning downwards lets the lowest set index overwrite any higher one.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            idx    = PW'(i);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_arb_mux.sv
// Packet-level N:1 mux: fixed-priority grant held for a whole packet, with a one-entry output register.
// Optional per-port completed-packet counters are enabled by PRIORITY_ARB_MUX_STATS_EN.
module priority_arb_mux
   import priority_arb_mux_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          in_valid,
   input  logic [N*DW-1:0]       in_data,
   input  logic [N-1:0]          in_last,
   output logic [N-1:0]          in_ready,
   output logic                  out_valid,
   output logic [DW-1:0]         out_data,
   output logic                  out_last,
   output logic [$clog2(N)-1:0]  out_port,
   input  logic                  out_ready,
`ifdef PRIORITY_ARB_MUX_STATS_EN
   output logic [N*PKT_CNT_W-1:0] pkt_cnt,
`endif
   output state_t                state_dbg
);

   localparam int PW = $clog2(N);

   // Handshake: a beat moves on a rising edge only when valid and ready are both
   // high; valid never waits for ready, and ready may depend on output state only.

   state_t         state_q, state_d;
   logic [PW-1:0]  sel_q, sel_d;
   logic [N-1:0]   sel_oh_q, sel_oh_d;
   logic [N-1:0]   enc_gnt;
   logic [PW-1:0]  enc_idx;
   logic           enc_any;
   logic           out_free;
   logic           accept;
   logic           last_acc;

   prio_sel_enc #(.N(N), .PW(PW)) u_sel_enc (
      .req (in_valid),
      .gnt (enc_gnt),
      .idx (enc_idx),
      .any (enc_any)
   );

   assign out_free  = !out_valid || out_ready;
   assign last_acc  = accept && in_last[sel_q];
   assign state_dbg = state_q;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      sel_oh_d = sel_oh_q;
      in_ready = '0;
      accept   = 1'b0;
      case (state_q)
         IDLE: begin
            if (enc_any) begin
               sel_d    = enc_idx;
               sel_oh_d = enc_gnt;
               state_d  = LOCK;
            end
         end
         LOCK: begin
            in_ready = sel_oh_q & {N{out_free}};
            accept   = |(in_valid & in_ready);
            if (accept && in_last[sel_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         sel_oh_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         sel_oh_q <= sel_oh_d;
      end
   end

   // A load in the same cycle as a drain simply replaces the departing beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_port  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data[sel_q*DW +: DW];
         out_last  <= in_last[sel_q];
         out_port  <= sel_q;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef PRIORITY_ARB_MUX_STATS_EN
   logic [N-1:0][PKT_CNT_W-1:0] pkt_cnt_q;

   for (genvar i = 0; i < N; i++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pkt_cnt_q[i] <= '0;
         end else if (last_acc && sel_q == PW'(i) && pkt_cnt_q[i] != PKT_CNT_MAX) begin
            pkt_cnt_q[i] <= pkt_cnt_q[i] + 1'b1;
         end
      end
   end

   assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_priority_arb_mux.sv
// Directed bench for priority_arb_mux: latency, priority, packet lock, backpressure, reset, stats.
// Beat-level scoreboard holds {last, port, data} in the hand-written expected order.
module tb_priority_arb_mux;
   import priority_arb_mux_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int PW = 2;
   localparam int W  = 1 + PW + DW;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      in_valid = '0;
   logic [N*DW-1:0]   in_data = '0;
   logic [N-1:0]      in_last = '0;
   logic [N-1:0]      in_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              out_last;
   logic [PW-1:0]     out_port;
   logic              out_ready = 1'b1;
   state_t            state_dbg;
`ifdef PRIORITY_ARB_MUX_STATS_EN
   logic [N*PKT_CNT_W-1:0] pkt_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] exp_q[$];
   logic         held_v = 1'b0;
   logic [W-1:0] held_beat;

   priority_arb_mux #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_port  (out_port),
      .out_ready (out_ready),
`ifdef PRIORITY_ARB_MUX_STATS_EN
      .pkt_cnt   (pkt_cnt),
`endif
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   function automatic logic [W-1:0] beat(input logic last, input logic [PW-1:0] port,
                                         input logic [DW-1:0] data);
      return {last, port, data};
   endfunction

   // Monitor: scoreboard on transfers, stability and ready-gating under backpressure.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            check("hold_valid", out_valid, 1);
            check("hold_beat", {out_last, out_port, out_data}, held_beat);
         end
         if (out_valid && !out_ready) begin
            check("bp_in_ready", in_ready, 0);
            held_v    = 1'b1;
            held_beat = {out_last, out_port, out_data};
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", exp_q.size(), 1);
            else check("beat", {out_last, out_port, out_data}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a falling edge; returns on a falling edge after the last beat.
   task automatic send_pkt(input int port, input int nbeats, input logic [DW-1:0] base);
      int waited;
      for (int b = 0; b < nbeats; b++) begin
         in_valid[port]           = 1'b1;
         in_data[port*DW +: DW]   = base + DW'(b);
         in_last[port]            = (b == nbeats - 1);
         waited = 0;
         #1;
         while (!in_ready[port] && waited <= 200) begin
            @(negedge clk);
            #1;
            waited++;
         end
         if (waited > 200) check("drv_timeout", waited, 0);
         @(negedge clk);
      end
      in_valid[port] = 1'b0;
      in_last[port]  = 1'b0;
   endtask

   task automatic push_pkt(input int port, input int nbeats, input logic [DW-1:0] base);
      for (int b = 0; b < nbeats; b++)
         exp_q.push_back(beat(b == nbeats - 1, PW'(port), base + DW'(b)));
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_port", out_port, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_state", state_dbg, IDLE);
      idle_cycles(2);
      rst_n = 1'b1;
      idle_cycles(2);

      // Single request, port 2, beats A B C, cycle-exact latency
      push_pkt(2, 3, 32'hA0);
      in_valid[2] = 1'b1; in_data[2*DW +: DW] = 32'hA0; in_last[2] = 1'b0;   // cycle 0
      #1;
      check("t1_c0_in_ready", in_ready, 0);
      check("t1_c0_state", state_dbg, IDLE);
      @(negedge clk);                                                         // cycle 1
      #1;
      check("t1_c1_in_ready", in_ready, 4'b0100);
      check("t1_c1_state", state_dbg, LOCK);
      check("t1_c1_out_valid", out_valid, 0);
      @(negedge clk);                                                         // cycle 2
      in_data[2*DW +: DW] = 32'hA1;
      #1;
      check("t1_c2_out_valid", out_valid, 1);
      check("t1_c2_out", {out_last, out_port, out_data}, beat(1'b0, 2'd2, 32'hA0));
      @(negedge clk);                                                         // cycle 3
      in_data[2*DW +: DW] = 32'hA2; in_last[2] = 1'b1;
      #1;
      check("t1_c3_out", {out_last, out_port, out_data}, beat(1'b0, 2'd2, 32'hA1));
      @(negedge clk);                                                         // cycle 4
      in_valid[2] = 1'b0; in_last[2] = 1'b0;
      #1;
      check("t1_c4_out", {out_last, out_port, out_data}, beat(1'b1, 2'd2, 32'hA2));
      check("t1_c4_state", state_dbg, IDLE);
      check("t1_c4_in_ready", in_ready, 0);
      @(negedge clk);                                                         // cycle 5
      #1;
      check("t1_c5_out_valid", out_valid, 0);
      idle_cycles(2);

      // Priority: ports 1 and 3 together, port 1 first
      push_pkt(1, 2, 32'h100);
      push_pkt(3, 2, 32'h300);
      fork
         send_pkt(1, 2, 32'h100);
         send_pkt(3, 2, 32'h300);
      join
      idle_cycles(4);

      // Lock: port 0 arrives while port 2 is mid-packet
      push_pkt(2, 4, 32'h200);
      push_pkt(0, 2, 32'h010);
      fork
         send_pkt(2, 4, 32'h200);
         begin
            idle_cycles(2);
            send_pkt(0, 2, 32'h010);
         end
      join
      idle_cycles(4);

      // Backpressure: out_ready low for 4 cycles mid-packet
      push_pkt(1, 5, 32'h500);
      fork
         send_pkt(1, 5, 32'h500);
         begin
            idle_cycles(3);
            out_ready = 1'b0;
            idle_cycles(4);
            out_ready = 1'b1;
         end
      join
      idle_cycles(4);
      check("bp_drained", exp_q.size(), 0);

      // Reset mid-packet: port 3, reset during beat 2 of 4
      exp_q.push_back(beat(1'b0, 2'd3, 32'hD0));
      in_valid[3] = 1'b1; in_data[3*DW +: DW] = 32'hD0; in_last[3] = 1'b0;   // n0
      @(negedge clk);                                                         // n1
      @(negedge clk);                                                         // n2
      in_data[3*DW +: DW] = 32'hD1;
      #3;
      rst_n = 1'b0;
      #1;
      check("t5_rst_out_valid", out_valid, 0);
      check("t5_rst_out_data", out_data, 0);
      check("t5_rst_out_port", out_port, 0);
      check("t5_rst_in_ready", in_ready, 0);
      check("t5_rst_state", state_dbg, IDLE);
      in_valid[3] = 1'b0;
      @(negedge clk);                                                         // n3
      rst_n = 1'b1;
      exp_q.push_back(beat(1'b1, 2'd1, 32'h77));
      in_valid[1] = 1'b1; in_data[1*DW +: DW] = 32'h77; in_last[1] = 1'b1;
      #1;
      check("t5_n3_out_valid", out_valid, 0);
      @(negedge clk);                                                         // n4
      #1;
      check("t5_n4_in_ready", in_ready, 4'b0010);
      check("t5_n4_out_valid", out_valid, 0);
      @(negedge clk);                                                         // n5
      in_valid[1] = 1'b0; in_last[1] = 1'b0;
      #1;
      check("t5_n5_out_valid", out_valid, 1);
      check("t5_n5_out", {out_last, out_port, out_data}, beat(1'b1, 2'd1, 32'h77));
      idle_cycles(3);
      check("t5_drained", exp_q.size(), 0);

`ifdef PRIORITY_ARB_MUX_STATS_EN
      // Stats: fresh reset, three packets from port 1, then saturation
      #3 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
         push_pkt(1, 2, 32'h900 + 32'(p * 16));
         send_pkt(1, 2, 32'h900 + 32'(p * 16));
      end
      idle_cycles(3);
      check("cnt_p0", pkt_cnt[0*16 +: 16], 0);
      check("cnt_p1", pkt_cnt[1*16 +: 16], 3);
      check("cnt_p2", pkt_cnt[2*16 +: 16], 0);
      check("cnt_p3", pkt_cnt[3*16 +: 16], 0);
      force dut.pkt_cnt_q[1] = 16'hFFFF;
      @(negedge clk);
      release dut.pkt_cnt_q[1];
      push_pkt(1, 1, 32'hF00);
      send_pkt(1, 1, 32'hF00);
      idle_cycles(3);
      check("cnt_sat", pkt_cnt[1*16 +: 16], 16'hFFFF);
`endif

      check("final_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
